// File: rtl/obi_burst_mgr.sv
// obi_burst_mgr -- OBI manager that expands one linear burst command into a
// sequence of single-beat OBI requests. Write beats come from a valid/ready
// stream and are consumed at grant. Read beats are buffered in a
// MaxOutstanding-deep FIFO and returned on a valid/ready stream. A credit
// counter bounds the number of granted-but-unanswered requests.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_*                 burst command (start address, beats-1, direction)
//   wdata_*, wbe_i        write beat stream (consumed on grant)
//   rdata_*               read beat stream
//   done_o                one-cycle pulse when the burst completes
//   err_o                 sticky error, cleared by the next command accept
//   obi_*                 OBI A/R channels (no atop, no rready)
//
// Build option: define OBI_BURST_MGR_ID_CHECK_EN to compare each obi_rid_i
// against an expected in-order ID and flag mismatches on err_o.
module obi_burst_mgr #(
   parameter int unsigned AddrWidth      = 48,
   parameter int unsigned DataWidth      = 512,
   parameter int unsigned IdWidth        = 4,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned LenWidth       = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic [AddrWidth-1:0]   cmd_addr_i,
   input  logic [LenWidth-1:0]    cmd_len_i,
   input  logic                   cmd_we_i,
   input  logic                   wdata_valid_i,
   output logic                   wdata_ready_o,
   input  logic [DataWidth-1:0]   wdata_i,
   input  logic [DataWidth/8-1:0] wbe_i,
   output logic                   rdata_valid_o,
   input  logic                   rdata_ready_i,
   output logic [DataWidth-1:0]   rdata_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic                   obi_req_o,
   input  logic                   obi_gnt_i,
   output logic [AddrWidth-1:0]   obi_addr_o,
   output logic                   obi_we_o,
   output logic [DataWidth/8-1:0] obi_be_o,
   output logic [DataWidth-1:0]   obi_wdata_o,
   output logic [IdWidth-1:0]     obi_aid_o,
   input  logic                   obi_rvalid_i,
   input  logic [DataWidth-1:0]   obi_rdata_i,
   input  logic [IdWidth-1:0]     obi_rid_i,
   input  logic                   obi_err_i
);

   localparam int unsigned BeWidth = DataWidth / 8;
   localparam int unsigned OffW    = $clog2(BeWidth);
   localparam int unsigned CntW    = LenWidth + 1;
   localparam int unsigned OutW    = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [AddrWidth-1:0] LowMask = AddrWidth'(BeWidth - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

   state_e                 state_q, state_d;
   logic [AddrWidth-1:0]   base_q;
   logic [LenWidth-1:0]    len_q;
   logic                   we_q;
   logic [CntW-1:0]        issue_cnt_q, resp_cnt_q;
   logic [OutW-1:0]        outst_q, fifo_cnt_q;
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [DataWidth-1:0]   fifo_mem_q [MaxOutstanding];
   logic                   a_pend_q;
   logic [DataWidth-1:0]   a_wdata_q;
   logic [BeWidth-1:0]     a_be_q;
   logic                   err_q, done_q, done_d;

   logic                   req, cmd_fire, gnt_fire, rsp_fire, push, pop;
   logic                   credit, slots_ok, issue_ok, last_issue, all_resp;
   logic [OutW-1:0]        free_slots;
   logic [CntW-1:0]        len_ext;
   logic                   id_mismatch;

   assign len_ext    = {1'b0, len_q};
   assign free_slots = OutW'(MaxOutstanding) - fifo_cnt_q;
   assign credit     = outst_q < OutW'(MaxOutstanding);
   // A read may only be issued if its response is guaranteed a FIFO slot.
   assign slots_ok   = free_slots > outst_q;
   assign issue_ok   = credit & (we_q ? wdata_valid_i : slots_ok);
   assign last_issue = issue_cnt_q == len_ext;
   assign all_resp   = resp_cnt_q == len_ext + CntW'(1);

   assign cmd_fire = cmd_valid_i & cmd_ready_o;
   assign gnt_fire = req & obi_gnt_i;
   // Responses outside a burst (stale after reset) are ignored.
   assign rsp_fire = obi_rvalid_i & (state_q != IDLE) & (outst_q != '0);
   assign push     = rsp_fire & ~we_q;
   assign pop      = rdata_valid_o & rdata_ready_i;

   always_comb begin
      state_d     = state_q;
      cmd_ready_o = 1'b0;
      req         = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) state_d = ISSUE;
         end
         ISSUE: begin
            // A pending request stays raised until granted.
            req = a_pend_q | issue_ok;
            if (req & obi_gnt_i & last_issue) state_d = DRAIN;
         end
         DRAIN: begin
            if (all_resp & (we_q | (fifo_cnt_q == '0))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A-channel fields are zero when no request is raised; while a request
   // waits for grant, write data/strobes come from the holding register so
   // they stay stable even if the stream input changes.
   assign obi_req_o   = req;
   assign obi_we_o    = req & we_q;
   assign obi_addr_o  = req ? base_q + (AddrWidth'(issue_cnt_q) << OffW) : '0;
   assign obi_aid_o   = req ? issue_cnt_q[IdWidth-1:0] : '0;
   assign obi_wdata_o = (req & we_q) ? (a_pend_q ? a_wdata_q : wdata_i) : '0;
   assign obi_be_o    = req ? (we_q ? (a_pend_q ? a_be_q : wbe_i) : '1) : '0;
   assign wdata_ready_o = gnt_fire & we_q;

   assign rdata_valid_o = fifo_cnt_q != '0;
   assign rdata_o       = rdata_valid_o ? fifo_mem_q[rd_ptr_q] : '0;
   assign done_o        = done_q;
   assign err_o         = err_q;

`ifdef OBI_BURST_MGR_ID_CHECK_EN
   logic [IdWidth-1:0] rid_exp_q;
   assign id_mismatch = rsp_fire & (obi_rid_i != rid_exp_q);
   always_ff @(posedge clk_i) begin
      if (rst_i || cmd_fire) rid_exp_q <= '0;
      else if (rsp_fire)     rid_exp_q <= rid_exp_q + IdWidth'(1);
   end
`else
   logic unused_rid;
   assign unused_rid  = ^obi_rid_i;
   assign id_mismatch = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         we_q        <= 1'b0;
         issue_cnt_q <= '0;
         resp_cnt_q  <= '0;
         outst_q     <= '0;
         fifo_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         a_pend_q    <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         done_q   <= done_d;
         a_pend_q <= req & ~obi_gnt_i;
         if (cmd_fire) begin
            base_q      <= cmd_addr_i & ~LowMask;
            len_q       <= cmd_len_i;
            we_q        <= cmd_we_i;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            err_q       <= 1'b0;
         end
         if (gnt_fire) issue_cnt_q <= issue_cnt_q + CntW'(1);
         if (rsp_fire) resp_cnt_q <= resp_cnt_q + CntW'(1);
         if ((rsp_fire & obi_err_i) | id_mismatch) err_q <= 1'b1;
         case ({gnt_fire, rsp_fire})
            2'b10:   outst_q <= outst_q + OutW'(1);
            2'b01:   outst_q <= outst_q - OutW'(1);
            default: outst_q <= outst_q;
         endcase
         if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
         if (push & ~pop)      fifo_cnt_q <= fifo_cnt_q + OutW'(1);
         else if (pop & ~push) fifo_cnt_q <= fifo_cnt_q - OutW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem_q[wr_ptr_q] <= obi_rdata_i;
      if (req & ~obi_gnt_i & ~a_pend_q) begin
         a_wdata_q <= wdata_i;
         a_be_q    <= wbe_i;
      end
   end

endmodule

// File: tb/tb_obi_burst_mgr.sv
module tb_obi_burst_mgr;
   localparam int unsigned AW = 48, DW = 512, IW = 4, MO = 4, LW = 16, BW = DW / 8;
   localparam logic [DW-1:0] RTAG = {240'h0, 16'hC0DE, 256'h0};
   localparam logic [BW-1:0] WBE  = {8{8'hA5}};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          wdata_valid = 1'b0, wdata_ready;
   logic [DW-1:0] wdata = '0;
   logic [BW-1:0] wbe = '0;
   logic          rdata_valid, rdata_ready = 1'b0;
   logic [DW-1:0] rdata;
   logic          done, err;
   logic          obi_req, obi_gnt = 1'b0, obi_we;
   logic [AW-1:0] obi_addr;
   logic [BW-1:0] obi_be;
   logic [DW-1:0] obi_wdata;
   logic [IW-1:0] obi_aid;
   logic          obi_rvalid;
   logic [DW-1:0] obi_rdata;
   logic [IW-1:0] obi_rid;
   logic          obi_rerr;

   int nvec = 0, nerr = 0;

   logic          err_en = 1'b0, bad_en = 1'b0;
   logic [IW-1:0] err_aid = '0, bad_aid = '0;

   always #5 clk = ~clk;

   obi_burst_mgr #(
      .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(MO), .LenWidth(LW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
      .cmd_len_i(cmd_len), .cmd_we_i(cmd_we),
      .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata), .wbe_i(wbe),
      .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
      .done_o(done), .err_o(err),
      .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
      .obi_be_o(obi_be), .obi_wdata_o(obi_wdata), .obi_aid_o(obi_aid),
      .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata), .obi_rid_i(obi_rid),
      .obi_err_i(obi_rerr)
   );

   // One-cycle subordinate: answers every granted request on the next cycle.
   // Read data is the request address tagged with RTAG.
   always @(posedge clk) begin
      if (rst) begin
         obi_rvalid <= 1'b0;
         obi_rdata  <= '0;
         obi_rid    <= '0;
         obi_rerr   <= 1'b0;
      end else begin
         obi_rvalid <= obi_req & obi_gnt;
         obi_rdata  <= DW'(obi_addr) | RTAG;
         obi_rid    <= (bad_en && obi_aid == bad_aid) ? IW'(2) : obi_aid;
         obi_rerr   <= err_en && (obi_aid == err_aid) && obi_req && obi_gnt;
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_we = w;
      #1;
      chk("cmd_ready", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output int cyc, output bit seen);
      seen = 1'b0; cyc = 0;
      for (int c = 1; c <= maxc; c++) begin
         @(negedge clk); #1;
         if (done === 1'b1) begin seen = 1'b1; cyc = c; break; end
      end
   endtask

   initial begin
      int  c, grants, beats;
      bit  s, seen;
      logic exp_id_err;
`ifdef OBI_BURST_MGR_ID_CHECK_EN
      exp_id_err = 1'b1;
`else
      exp_id_err = 1'b0;
`endif

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_req", obi_req, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rvalid", rdata_valid, 0);
      rst = 1'b0;

      // Write burst: 0x1000, 4 beats, gnt tied high
      wdata_valid = 1'b1; wbe = WBE; obi_gnt = 1'b1;
      send_cmd(48'h1000, 16'd3, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         wdata = DW'(k);
         #1;
         chk("w1_req", obi_req, 1);
         chk("w1_addr", obi_addr, AW'(48'h1000 + 64 * k));
         chk("w1_aid", obi_aid, k);
         chk("w1_wdata", obi_wdata, k);
         chk("w1_wready", wdata_ready, 1);
      end
      chk("w1_we", obi_we, 1);
      chk("w1_be", obi_be, WBE);
      @(negedge clk);
      wdata_valid = 1'b0;
      #1;
      chk("w1_req_off", obi_req, 0);
      wait_done(10, c, s);
      chk("w1_done_seen", s, 1);
      chk("w1_done_lat", c, 2);
      chk("w1_done_ready", cmd_ready, 1);
      chk("w1_err", err, 0);
      chk("w1_no_rdata", rdata_valid, 0);
      @(negedge clk); #1;
      chk("w1_done_pulse", done, 0);

      // Read burst: 8 beats with rdata_ready held low
      rdata_ready = 1'b0;
      send_cmd(48'h2000, 16'd7, 1'b0);
      grants = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (obi_req && obi_gnt) grants++;
         if (i == 0) begin
            chk("r2_be_ones", obi_be, {BW{1'b1}});
            chk("r2_we", obi_we, 0);
         end
         if (i == 1) chk("r2_rv_early", rdata_valid, 0);
         if (i == 2) chk("r2_rv_first", rdata_valid, 1);
      end
      chk("r2_grants", grants, 4);
      chk("r2_req_blocked", obi_req, 0);
      chk("r2_no_done", done, 0);
      rdata_ready = 1'b1;
      beats = 0; seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            chk("r2_done_after_pop", beats, 8);
            chk("r2_done_empty", rdata_valid, 0);
         end else begin
            if (rdata_valid === 1'b1) begin
               chk("r2_data", rdata, DW'(AW'(48'h2000 + 64 * beats)) | RTAG);
               beats++;
            end
            @(negedge clk); #1;
         end
      end
      chk("r2_done_seen", seen, 1);

      // Grant stall on beat 2 of a write burst
      wdata_valid = 1'b1; obi_gnt = 1'b1; wdata = '0;
      send_cmd(48'h3000, 16'd3, 1'b1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         wdata = DW'(12'h100 + k);
         #1;
         chk("g3_addr", obi_addr, AW'(48'h3000 + 64 * k));
      end
      @(negedge clk);
      wdata = DW'(12'h102); obi_gnt = 1'b0;
      #1;
      for (int s5 = 0; s5 < 5; s5++) begin
         chk("g3_stall_req", obi_req, 1);
         chk("g3_stall_addr", obi_addr, 48'h3080);
         chk("g3_stall_aid", obi_aid, 2);
         chk("g3_stall_wdata", obi_wdata, 12'h102);
         chk("g3_stall_wready", wdata_ready, 0);
         @(negedge clk);
         wdata = {16{32'hDEAD_BEEF}};
         #1;
      end
      obi_gnt = 1'b1;
      #1;
      chk("g3_gnt_wready", wdata_ready, 1);
      chk("g3_gnt_wdata", obi_wdata, 12'h102);
      @(negedge clk);
      wdata = DW'(12'h103);
      #1;
      chk("g3_last_addr", obi_addr, 48'h30C0);
      chk("g3_last_aid", obi_aid, 3);
      @(negedge clk);
      wdata_valid = 1'b0;
      #1;
      wait_done(10, c, s);
      chk("g3_done_seen", s, 1);
      chk("g3_done_lat", c, 2);

      // Error on beat 1 of a 3-beat read
      rdata_ready = 1'b1; err_en = 1'b1; err_aid = IW'(1);
      send_cmd(48'h4000, 16'd2, 1'b0);
      beats = 0; seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk); #1;
         if (i == 2) chk("e4_err_before", err, 0);
         if (i == 3) chk("e4_err_set", err, 1);
         if (done === 1'b1) seen = 1'b1;
         else if (rdata_valid === 1'b1) begin
            chk("e4_data", rdata, DW'(AW'(48'h4000 + 64 * beats)) | RTAG);
            beats++;
         end
      end
      chk("e4_done_seen", seen, 1);
      chk("e4_beats", beats, 3);
      chk("e4_err_hold", err, 1);
      err_en = 1'b0;

      // Address wrap (low bits of start address ignored); err cleared on accept
      @(negedge clk); #1;
      chk("w5_err_sticky", err, 1);
      wdata_valid = 1'b1; wdata = DW'(32'h55);
      send_cmd(48'hFFFF_FFFF_FFC5, 16'd1, 1'b1);
      @(negedge clk); #1;
      chk("w5_err_clr", err, 0);
      chk("w5_addr0", obi_addr, 48'hFFFF_FFFF_FFC0);
      @(negedge clk); #1;
      chk("w5_req1", obi_req, 1);
      chk("w5_addr_wrap", obi_addr, 48'h0);
      chk("w5_aid1", obi_aid, 1);
      @(negedge clk);
      wdata_valid = 1'b0;
      #1;
      wait_done(10, c, s);
      chk("w5_done_seen", s, 1);

      // Reset in the middle of a read burst
      rdata_ready = 1'b0;
      send_cmd(48'h5000, 16'd7, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("x6_cmd_ready", cmd_ready, 1);
      chk("x6_req", obi_req, 0);
      chk("x6_rvalid", rdata_valid, 0);
      chk("x6_rdata", rdata, 0);
      chk("x6_done", done, 0);
      chk("x6_err", err, 0);
      chk("x6_wready", wdata_ready, 0);
      chk("x6_addr", obi_addr, 0);
      chk("x6_aid", obi_aid, 0);
      chk("x6_we", obi_we, 0);
      chk("x6_be", obi_be, 0);
      chk("x6_wdata", obi_wdata, 0);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("x6_idle_ready", cmd_ready, 1);
      chk("x6_idle_rvalid", rdata_valid, 0);

      // Response ID mismatch on beat 1
      rdata_ready = 1'b1; bad_en = 1'b1; bad_aid = IW'(1);
      send_cmd(48'h6000, 16'd2, 1'b0);
      beats = 0; seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk); #1;
         if (done === 1'b1) seen = 1'b1;
         else if (rdata_valid === 1'b1) begin
            chk("i7_data", rdata, DW'(AW'(48'h6000 + 64 * beats)) | RTAG);
            beats++;
         end
      end
      chk("i7_done_seen", seen, 1);
      chk("i7_beats", beats, 3);
      chk("i7_err", err, exp_id_err);
      bad_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
